// File: rtl/sparc_mul_mc_pkg.sv
// Shared definitions for the multi-channel multiply/MAC unit:
// op encodings, per-stage control payload and default sizing.
package sparc_mul_mc_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_NCH   = 2;
    localparam int DEF_LAT   = 5;
    localparam int MAX_NCH   = 8;
    localparam int CH_BITS   = 3;

    typedef enum logic [1:0] {
        MODE_MUL = 2'b00,
        MODE_MAC = 2'b01,
        MODE_SHF = 2'b10,
        MODE_CLR = 2'b11
    } mul_mode_e;

    // Control half of a pipeline stage; the product travels alongside it.
    typedef struct packed {
        logic               vld;
        logic [CH_BITS-1:0] ch;
        mul_mode_e          mode;
    } stage_ctl_t;

endpackage

// File: rtl/sparc_mul_rr_arb.sv
// Round-robin issue arbiter: one grant per cycle, search starts at the
// pointer, pointer moves past the winner.
module sparc_mul_rr_arb #(
    parameter int NCH = 2,
    parameter int CHW = 1
) (
    input  logic           rclk,
    input  logic           grst,
    input  logic [NCH-1:0] req_vld,
    output logic [NCH-1:0] gnt,
    output logic           gnt_any,
    output logic [CHW-1:0] gnt_idx
);

    logic [CHW-1:0] ptr;
    logic [CHW-1:0] cand;

    // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        gnt     = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = CHW'((int'(ptr) + i) % NCH);
            if (!gnt_any && req_vld[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (grst) gnt_any = 1'b0;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge rclk) begin
        if (grst)
            ptr <= '0;
        else if (gnt_any)
            ptr <= (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/sparc_mul_mc.sv
// Multi-channel pipelined multiply / multiply-accumulate unit with
// per-channel accumulators and in-order shared result bus.
module sparc_mul_mc_top
    import sparc_mul_mc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int LAT   = DEF_LAT,
    parameter int ACCW  = 2 * WIDTH + 8
) (
    input  logic               rclk,
    input  logic               grst,
    input  logic [NCH-1:0]     req_vld,
    input  logic [2*NCH-1:0]   req_mode,
    input  logic [NCH*WIDTH-1:0] req_op1,
    input  logic [NCH*WIDTH-1:0] req_op2,
    output logic [NCH-1:0]     req_gnt,
    output logic [NCH-1:0]     mul_ack,
    output logic [1:0]         mul_ack_mode,
    output logic [WIDTH-1:0]   mul_data_out
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = 2 * WIDTH;

    logic           gnt_any;
    logic [CHW-1:0] gnt_idx;

    sparc_mul_rr_arb #(.NCH(NCH), .CHW(CHW)) u_arb (
        .rclk    (rclk),
        .grst    (grst),
        .req_vld (req_vld),
        .gnt     (req_gnt),
        .gnt_any (gnt_any),
        .gnt_idx (gnt_idx)
    );

    logic [WIDTH-1:0] iss_op1, iss_op2;
    mul_mode_e        iss_mode;

    always_comb begin
        iss_op1  = req_op1[gnt_idx*WIDTH +: WIDTH];
        iss_op2  = req_op2[gnt_idx*WIDTH +: WIDTH];
        iss_mode = mul_mode_e'(req_mode[gnt_idx*2 +: 2]);
    end

    // Index k holds stage k+1; stage 1 carries the freshly formed product.
    stage_ctl_t     s_ctl  [LAT-1];
    logic [PW-1:0]  s_prod [LAT-1];

    always_ff @(posedge rclk) begin
        if (grst) begin
            for (int k = 0; k < LAT - 1; k++) s_ctl[k] <= '0;
        end else begin
            s_ctl[0] <= '{vld: gnt_any, ch: CH_BITS'(gnt_idx), mode: iss_mode};
            for (int k = 1; k < LAT - 1; k++) s_ctl[k] <= s_ctl[k-1];
        end
    end

    // NOTE: the product path carries no reset; only the valid bits decide whether it is used.
    always_ff @(posedge rclk) begin
        s_prod[0] <= PW'(iss_op1) * PW'(iss_op2);
        for (int k = 1; k < LAT - 1; k++) s_prod[k] <= s_prod[k-1];
    end

    stage_ctl_t       tail;
    logic [PW-1:0]    tail_prod;
    logic [CHW-1:0]   tail_ch;
    logic [ACCW-1:0]  acc_q [NCH];
    logic [ACCW-1:0]  acc_cur, acc_nxt;
    logic [WIDTH-1:0] res;

    always_comb begin
        tail      = s_ctl[LAT-2];
        tail_prod = s_prod[LAT-2];
        tail_ch   = CHW'(tail.ch);
        acc_cur   = acc_q[tail_ch];
        acc_nxt   = acc_cur;
        res       = tail_prod[WIDTH-1:0];
        case (tail.mode)
            MODE_MAC: begin
                acc_nxt = acc_cur + ACCW'(tail_prod);
                res     = acc_nxt[WIDTH-1:0];
            end
            MODE_SHF: begin
                acc_nxt = acc_cur >> WIDTH;
                res     = acc_nxt[WIDTH-1:0];
            end
            MODE_CLR: begin
                acc_nxt = '0;
                res     = '0;
            end
            default: ;
        endcase
    end

    // NOTE: the accumulators are architectural state and must clear on reset, so the array is reset element by element.
    always_ff @(posedge rclk) begin
        if (grst) begin
            for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
            mul_ack      <= '0;
            mul_ack_mode <= '0;
            mul_data_out <= '0;
        end else begin
            mul_ack <= '0;
            if (tail.vld) begin
                acc_q[tail_ch]   <= acc_nxt;
                mul_ack[tail_ch] <= 1'b1;
                mul_ack_mode     <= tail.mode;
                mul_data_out     <= res;
            end
        end
    end

endmodule

// File: tb/tb_sparc_mul_mc_top.sv
// Directed checks on the default configuration plus a modelled random
// sweep on a 4-channel, 2-cycle, 32-bit instance.
module tb_sparc_mul_mc_top;
    import sparc_mul_mc_pkg::*;

    localparam int W  = 64, N  = 2, L  = 5;
    localparam int W2 = 32, N2 = 4, L2 = 2, A2 = 72;

    logic rclk = 1'b0;
    logic grst;
    always #5 rclk = ~rclk;

    logic [N-1:0]   req_vld;
    logic [2*N-1:0] req_mode;
    logic [N*W-1:0] req_op1, req_op2;
    logic [N-1:0]   req_gnt, mul_ack;
    logic [1:0]     mul_ack_mode;
    logic [W-1:0]   mul_data_out;

    logic [N2-1:0]    sw_req_vld;
    logic [2*N2-1:0]  sw_req_mode;
    logic [N2*W2-1:0] sw_req_op1, sw_req_op2;
    logic [N2-1:0]    sw_req_gnt, sw_mul_ack;
    logic [1:0]       sw_mul_ack_mode;
    logic [W2-1:0]    sw_mul_data_out;

    sparc_mul_mc_top #(.WIDTH(W), .NCH(N), .LAT(L)) u_dut (
        .rclk(rclk), .grst(grst), .req_vld(req_vld), .req_mode(req_mode),
        .req_op1(req_op1), .req_op2(req_op2), .req_gnt(req_gnt),
        .mul_ack(mul_ack), .mul_ack_mode(mul_ack_mode), .mul_data_out(mul_data_out)
    );

    sparc_mul_mc_top #(.WIDTH(W2), .NCH(N2), .LAT(L2)) u_dut_sw (
        .rclk(rclk), .grst(grst), .req_vld(sw_req_vld), .req_mode(sw_req_mode),
        .req_op1(sw_req_op1), .req_op2(sw_req_op2), .req_gnt(sw_req_gnt),
        .mul_ack(sw_mul_ack), .mul_ack_mode(sw_mul_ack_mode), .mul_data_out(sw_mul_data_out)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge rclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    typedef struct {
        int          due;
        int          ch;
        logic [1:0]  mode;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;

    // Every cycle either the scheduled ack appears or the ack bus is silent.
    always @(negedge rclk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                check("ack_vec",  128'(mul_ack),      128'(1 << mon_e.ch));
                check("ack_mode", 128'(mul_ack_mode), 128'(mon_e.mode));
                check("ack_data", 128'(mul_data_out), 128'(mon_e.data));
            end else begin
                check("no_ack", 128'(mul_ack), 128'(0));
            end
        end
    end

    task automatic issue(input int ch, input logic [1:0] mode, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_data, input bit want);
        @(posedge rclk); #1;
        req_vld = N'(1) << ch;
        req_mode[2*ch +: 2] = mode;
        req_op1[ch*W +: W]  = a;
        req_op2[ch*W +: W]  = b;
        @(negedge rclk);
        check("gnt", 128'(req_gnt), 128'(1 << ch));
        if (want) exp_q.push_back('{due: cyc + L, ch: ch, mode: mode, data: exp_data});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge rclk); #1;
            req_vld = '0;
        end
    endtask

    // Sweep-instance model state
    bit              m_vld [N2];
    logic [1:0]      m_mode[N2];
    logic [W2-1:0]   m_a[N2], m_b[N2];
    logic [A2-1:0]   m_acc[N2];
    int              m_ptr, g, r;
    bit              found;
    logic [63:0]     p;
    logic [W2-1:0]   d;

    task automatic sw_ack_check();
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("sw_ack_vec",  128'(sw_mul_ack),      128'(1 << e.ch));
            check("sw_ack_mode", 128'(sw_mul_ack_mode), 128'(e.mode));
            check("sw_ack_data", 128'(sw_mul_data_out), 128'(e.data[W2-1:0]));
        end else begin
            check("sw_no_ack", 128'(sw_mul_ack), 128'(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        grst = 1'b1;
        req_vld = '0; req_mode = '0; req_op1 = '0; req_op2 = '0;
        sw_req_vld = '0; sw_req_mode = '0; sw_req_op1 = '0; sw_req_op2 = '0;
        repeat (3) @(posedge rclk);
        #1 req_vld = 2'b11;
        @(negedge rclk);
        check("rst_gnt",  128'(req_gnt),      128'(0));
        check("rst_ack",  128'(mul_ack),      128'(0));
        check("rst_mode", 128'(mul_ack_mode), 128'(0));
        check("rst_data", 128'(mul_data_out), 128'(0));
        @(posedge rclk); #1;
        grst = 1'b0;
        req_vld = '0;
        mon_en = 1'b1;

        // Both channels requesting: grants alternate starting at channel 0
        @(posedge rclk); #1;
        req_vld = 2'b11;
        req_mode = {MODE_MUL, MODE_MUL};
        req_op1 = {64'd7, 64'd3};
        req_op2 = {64'd9, 64'd5};
        for (int i = 0; i < 6; i++) begin
            @(negedge rclk);
            check("rr_gnt", 128'(req_gnt), 128'((i % 2 == 0) ? 1 : 2));
            exp_q.push_back('{due: cyc + L, ch: i % 2, mode: MODE_MUL,
                              data: (i % 2 == 0) ? 64'd15 : 64'd63});
            @(posedge rclk);
        end
        #1 req_vld = '0;

        issue(0, MODE_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);

        issue(1, MODE_MAC, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b1);
        issue(1, MODE_MAC, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b1);
        issue(1, MODE_MAC, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b1);
        issue(1, MODE_SHF, 64'd123, 64'd456, 64'd3, 1'b1);
        issue(1, MODE_SHF, 64'd0, 64'd0, 64'd0, 1'b1);
        issue(0, MODE_MAC, 64'd1, 64'd1, 64'd1, 1'b1);

        issue(0, MODE_MAC, 64'd5, 64'd7, 64'd36, 1'b1);
        issue(0, MODE_CLR, 64'd9, 64'd9, 64'd0, 1'b1);
        issue(0, MODE_MAC, 64'd1, 64'd1, 64'd1, 1'b1);
        idle(L + 3);

        // Reset with three ops in flight; none of them may ever be acked
        issue(0, MODE_MUL, 64'd11, 64'd11, 64'd0, 1'b0);
        issue(1, MODE_MAC, 64'd3, 64'd3, 64'd0, 1'b0);
        issue(0, MODE_MAC, 64'd2, 64'd2, 64'd0, 1'b0);
        @(posedge rclk); #1;
        grst = 1'b1;
        req_vld = 2'b11;
        @(negedge rclk);
        check("midrst_gnt", 128'(req_gnt), 128'(0));
        @(posedge rclk);
        @(negedge rclk);
        check("midrst_ack",  128'(mul_ack),      128'(0));
        check("midrst_mode", 128'(mul_ack_mode), 128'(0));
        check("midrst_data", 128'(mul_data_out), 128'(0));
        @(posedge rclk); #1;
        grst = 1'b0;
        req_mode = {MODE_MUL, MODE_MAC};
        req_op1 = {64'd2, 64'd4};
        req_op2 = {64'd3, 64'd4};
        @(negedge rclk);
        check("post_rst_gnt0", 128'(req_gnt), 128'(1));
        exp_q.push_back('{due: cyc + L, ch: 0, mode: MODE_MAC, data: 64'd16});
        @(posedge rclk); #1;
        req_vld = 2'b10;
        @(negedge rclk);
        check("post_rst_gnt1", 128'(req_gnt), 128'(2));
        exp_q.push_back('{due: cyc + L, ch: 1, mode: MODE_MUL, data: 64'd6});
        idle(L + 3);
        check("dir_drained", 128'(exp_q.size()), 128'(0));
        mon_en = 1'b0;

        // Sweep instance: saturating MAC phase forces accumulator wrap, then mixed traffic
        m_ptr = 0;
        for (int c = 0; c < N2; c++) begin
            m_vld[c] = 1'b0; m_acc[c] = '0; m_mode[c] = MODE_MUL; m_a[c] = '0; m_b[c] = '0;
        end
        for (int t = 0; t < 2400; t++) begin
            @(posedge rclk); #1;
            for (int c = 0; c < N2; c++) begin
                if (!m_vld[c] && $urandom_range(0, 3) != 0) begin
                    m_vld[c] = 1'b1;
                    if (t < 1200) begin
                        m_mode[c] = MODE_MAC; m_a[c] = '1; m_b[c] = '1;
                    end else begin
                        r = $urandom_range(0, 19);
                        m_mode[c] = (r < 8) ? MODE_MUL : (r < 16) ? MODE_MAC : (r < 18) ? MODE_SHF : MODE_CLR;
                        m_a[c] = $urandom;
                        m_b[c] = $urandom;
                    end
                end
                sw_req_vld[c] = m_vld[c];
                sw_req_mode[2*c +: 2] = m_mode[c];
                sw_req_op1[c*W2 +: W2] = m_a[c];
                sw_req_op2[c*W2 +: W2] = m_b[c];
            end
            @(negedge rclk);
            sw_ack_check();
            found = 1'b0;
            g = 0;
            for (int i = 0; i < N2; i++) begin
                if (!found && m_vld[(m_ptr + i) % N2]) begin
                    found = 1'b1;
                    g = (m_ptr + i) % N2;
                end
            end
            check("sw_gnt", 128'(sw_req_gnt), found ? 128'(1 << g) : 128'(0));
            if (found) begin
                p = 64'(m_a[g]) * 64'(m_b[g]);
                d = p[W2-1:0];
                case (m_mode[g])
                    MODE_MAC: begin m_acc[g] = m_acc[g] + A2'(p); d = m_acc[g][W2-1:0]; end
                    MODE_SHF: begin m_acc[g] = m_acc[g] >> W2;    d = m_acc[g][W2-1:0]; end
                    MODE_CLR: begin m_acc[g] = '0;                d = '0; end
                    default: ;
                endcase
                exp_q.push_back('{due: cyc + L2, ch: g, mode: m_mode[g], data: W'(d)});
                m_vld[g] = 1'b0;
                m_ptr = (g + 1) % N2;
            end
        end
        @(posedge rclk); #1;
        sw_req_vld = '0;
        @(negedge rclk);
        sw_ack_check();
        repeat (L2 + 2) begin
            @(negedge rclk);
            sw_ack_check();
        end
        check("sw_drained", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sparc_mul_mc_top.md
# sparc_mul_mc_top

Parametrised, fully pipelined multi-channel multiply/multiply-accumulate unit; successor to the two-client (EXU + SPU) core multiplier. It serves NCH independent requesters through a round-robin issue arbiter, keeps one private accumulator per channel, and returns results in issue order on a shared data bus with per-channel acks. It sits between the core execution/crypto units and is the only multiplier instance in the core.

## Interface
- WIDTH, 64: operand and result width.
- NCH, 2: number of requesting channels (1..8).
- LAT, 5: issue-to-ack latency in cycles (≥2).
- ACCW, 2*WIDTH+8: accumulator width per channel.
- rclk  in  1  core clock; all state on rising edge.
- grst  in  1  reset; synchronous, active-high.
- req_vld  in  NCH  per-channel request valid (level).
- req_mode  in  2*NCH  per-channel op: 00 MUL, 01 MAC, 10 SHF, 11 CLR.
- req_op1  in  NCH*WIDTH  per-channel operand 1.
- req_op2  in  NCH*WIDTH  per-channel operand 2.
- req_gnt  out  NCH  one-hot accept strobe (combinational from req_vld, pointer).
- mul_ack  out  NCH  one-hot result strobe.
- mul_ack_mode  out  2  op code of the acked request.
- mul_data_out  out  WIDTH  shared result bus, valid when any mul_ack bit is high.

## Operation
- Issue: each cycle at most one request accepted. Accepted = req_vld[c] & req_gnt[c]. Requester holds vld/mode/operands stable until granted; may drop vld only after gnt.
- Arbitration: round-robin; pointer starts at channel 0, moves to (granted+1) mod NCH after each grant; unchanged when nothing granted. Single requester granted every cycle.
- Ops (unsigned; product P = op1*op2, 2*WIDTH bits):
  - MUL: out = P[WIDTH-1:0]; accumulator untouched.
  - MAC: acc[c] = (acc[c] + P) mod 2^ACCW; out = new acc[c][WIDTH-1:0].
  - SHF: acc[c] = acc[c] >> WIDTH (zero fill); out = new acc[c][WIDTH-1:0]; operands ignored.
  - CLR: acc[c] = 0; out = 0; operands ignored.
- All ops travel the full pipeline; accumulator read-modify-write happens only in the final stage, so back-to-back ops to the same channel need no stall or bypass and are applied in issue order.
- Product formed in stage 1 (registered); stages 2..LAT-1 are delay registers carrying {valid, channel, mode, product}; stage LAT performs accumulator update and drives outputs.
- Accumulators of different channels are fully independent.

## Timing
- Request granted in cycle t → mul_ack[c] high exactly in cycle t+LAT for one cycle, with mul_data_out and mul_ack_mode valid the same cycle.
- Throughput: one op per cycle sustained, no bubbles, no backpressure on results (consumers must sink every ack).
- Results emerge strictly in grant order across all channels.
- mul_data_out holds last value when no ack (not required to be zero, but equal to 0 after reset until first ack).
- Reset (grst high at an edge): all pipeline valids cleared, every acc[c]=0, pointer=0, mul_ack=0, mul_ack_mode=00, mul_data_out=0. In-flight ops are discarded and never acked. req_gnt=0 while grst high.
- Reset mid-operation: first ack after reset release comes LAT cycles after the first post-reset grant.
- Simultaneous MAC to acc[c] in stage LAT and new grant for channel c: both legal; new op sees the updated value when it reaches stage LAT.

## Structure
- Package sparc_mul_mc_pkg: mode encodings (MUL/MAC/SHF/CLR), stage payload struct typedef, default parameter constants.
- Sub-module sparc_mul_rr_arb (NCH-wide round-robin arbiter, pointer register, grst clears); everything else in the top.
- Multiplier written behaviourally (single `*`) in stage 1; synthesis retimes across the delay stages.

## Test plan
- Single MUL, ch0, op1=0xFFFF_FFFF_FFFF_FFFF, op2=2 → mul_ack[0] at t+5, data=0xFFFF_FFFF_FFFF_FFFE, mode=00.
- ch1 MAC×3 back-to-back with (2^32)·(2^32) each → data 0,0,0; then SHF → data=3; second SHF → data=0; acc[0] unaffected (ch0 MAC 1·1 → data=1).
- Both channels hold vld for 6 cycles → grants alternate 0,1,0,1,0,1; acks same order at +LAT, no gaps.
- CLR on ch0 after MAC 5·7 → ack data=0; following MAC 1·1 → data=1.
- Assert grst with 3 ops in flight → no acks afterwards, all outputs 0, pointer 0; post-release MAC 4·4 → data=16.
- Sweep NCH=4, LAT=2, WIDTH=32 with random traffic against a reference model: per-grant ack at +2, in-order, accumulator wrap at 2^72.
